// File: rtl/mv_decode_sched.sv
// Motion-vector decode scheduler: walks the (r, s) vectors of one macroblock
// through a shared datapath using a start/done handshake, with a hang timeout.
module mv_decode_sched #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mb_start,
  input  logic       mv_forward,
  input  logic       mv_backward,
  input  logic [1:0] mv_count,
  input  logic       dmv,
  input  logic       mvscale,
  input  logic       mv_done,
  output logic       mv_start,
  output logic       mv_r,
  output logic       mv_s,
  output logic       mv_dmv,
  output logic       mv_mvscale,
  output logic       busy,
  output logic       mb_done,
  output logic       err,
  output logic [2:0] vec_issued
);

  // state | meaning
  // IDLE  | waiting for mb_start; latches macroblock header fields
  // ISSUE | one-cycle mv_start for the current (r, s)
  // WAIT  | waiting for mv_done, timeout counter running
  // NEXT  | step to the next (r, s); also the settle cycle for empty/illegal MBs
  // DONE  | one-cycle mb_done
  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic       fwd_q;
  logic       bwd_q;
  logic       two_q;
  logic       skip_q;
  logic [7:0] tmo_cnt;
  logic       cnt_ok;
  logic       mb_empty;
  logic       timeout_hit;
  logic       has_next;
  logic       next_r;
  logic       next_s;

  assign cnt_ok      = dmv | (mv_count == 2'd1) | (mv_count == 2'd2);
  assign mb_empty    = ~mv_forward & ~mv_backward;
  assign timeout_hit = (tmo_cnt == TMO_LAST);

  // Visit order (0,0) (1,0) (0,1) (1,1), restricted to enabled directions/count.
  always_comb begin
    has_next = 1'b0;
    next_r   = 1'b0;
    next_s   = 1'b0;
    if (!skip_q) begin
      if (two_q && !mv_r) begin
        has_next = 1'b1;
        next_r   = 1'b1;
        next_s   = mv_s;
      end else if (!mv_s && bwd_q) begin
        has_next = 1'b1;
        next_r   = 1'b0;
        next_s   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (mb_start) state_nxt = (cnt_ok && !mb_empty) ? S_ISSUE : S_NEXT;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (mv_done)          state_nxt = S_NEXT;
        else if (timeout_hit) state_nxt = S_DONE;
      end
      S_NEXT:  state_nxt = has_next ? S_ISSUE : S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mv_start = 1'b0;
    busy     = 1'b1;
    mb_done  = 1'b0;
    case (state)
      S_IDLE:  busy     = 1'b0;
      S_ISSUE: mv_start = 1'b1;
      S_DONE:  mb_done  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_q      <= 1'b0;
      bwd_q      <= 1'b0;
      two_q      <= 1'b0;
      skip_q     <= 1'b0;
      tmo_cnt    <= '0;
      mv_r       <= 1'b0;
      mv_s       <= 1'b0;
      mv_dmv     <= 1'b0;
      mv_mvscale <= 1'b0;
      err        <= 1'b0;
      vec_issued <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mb_start) begin
            fwd_q      <= mv_forward;
            bwd_q      <= mv_backward;
            two_q      <= !dmv && (mv_count == 2'd2);
            skip_q     <= !(cnt_ok && !mb_empty);
            mv_dmv     <= dmv;
            mv_mvscale <= mvscale;
            mv_r       <= 1'b0;
            mv_s       <= !mv_forward;
            err        <= !cnt_ok;
            vec_issued <= '0;
          end
        end
        S_ISSUE: begin
          vec_issued <= vec_issued + 3'd1;
          tmo_cnt    <= '0;
        end
        S_WAIT: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (!mv_done && timeout_hit) err <= 1'b1;
        end
        S_NEXT: begin
          if (has_next) begin
            mv_r <= next_r;
            mv_s <= next_s;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
